// File: rtl/rast_params.sv
// Shared rasterizer parameters: fixed-point format, triangle shape,
// feeder FIFO depth and cull counter width.
package rast_params;

    localparam int SIGFIG     = 24;
    localparam int RADIX      = 10;
    localparam int VERTS      = 3;
    localparam int AXIS       = 3;
    localparam int COLORS     = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int CULL_W     = 16;

endpackage

// File: rtl/tri_cull.sv
// Trivial-reject test: a triangle entirely off one screen edge
// (x or y, left/right/top/bottom) cannot cover any pixel.
module tri_cull
    import rast_params::*;
#(
    parameter int SIGFIG = rast_params::SIGFIG,
    parameter int VERTS  = rast_params::VERTS,
    parameter int AXIS   = rast_params::AXIS
) (
    input  logic signed [SIGFIG-1:0] tri_S [VERTS][AXIS],
    input  logic signed [SIGFIG-1:0] screen_S [2],
    output logic                     reject
);

    logic all_xl;
    logic all_xh;
    logic all_yl;
    logic all_yh;

    // AND each off-edge condition across every vertex
    always_comb begin
        all_xl = 1'b1;
        all_xh = 1'b1;
        all_yl = 1'b1;
        all_yh = 1'b1;
        for (int v = 0; v < VERTS; v++) begin
            all_xl &= (tri_S[v][0] < 0);
            all_xh &= (tri_S[v][0] >= screen_S[0]);
            all_yl &= (tri_S[v][1] < 0);
            all_yh &= (tri_S[v][1] >= screen_S[1]);
        end
        reject = all_xl | all_xh | all_yl | all_yh;
    end

endmodule

// File: rtl/tri_feeder.sv
// Triangle FIFO in front of the rasterizer: drops trivially rejected
// triangles, queues the rest and presents the head entry at R10.
module tri_feeder
    import rast_params::*;
#(
    parameter int SIGFIG = rast_params::SIGFIG,
    parameter int VERTS  = rast_params::VERTS,
    parameter int AXIS   = rast_params::AXIS,
    parameter int COLORS = rast_params::COLORS,
    parameter int DEPTH  = rast_params::FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [SIGFIG-1:0]    tri_in_S [VERTS][AXIS],
    input  logic unsigned [SIGFIG-1:0]  color_in_U [COLORS],
    input  logic                        valid_in_H,
    output logic                        ready_in_H,
    input  logic signed [SIGFIG-1:0]    screen_RnnnnS [2],
    input  logic                        halt_RnnnnL,
    output logic signed [SIGFIG-1:0]    tri_R10S [VERTS][AXIS],
    output logic unsigned [SIGFIG-1:0]  color_R10U [COLORS],
    output logic                        validTri_R10H,
    output logic [$clog2(DEPTH):0]      occupancy_U,
    output logic [CULL_W-1:0]           cull_count_U
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    logic signed [SIGFIG-1:0]   tri_mem   [DEPTH][VERTS][AXIS];
    logic unsigned [SIGFIG-1:0] color_mem [DEPTH][COLORS];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          reject;
    logic          push;
    logic          enq;
    logic          pop;

    tri_cull #(
        .SIGFIG (SIGFIG),
        .VERTS  (VERTS),
        .AXIS   (AXIS)
    ) u_cull (
        .tri_S    (tri_in_S),
        .screen_S (screen_RnnnnS),
        .reject   (reject)
    );

    assign ready_in_H    = (occupancy_U < FULL);
    assign validTri_R10H = (occupancy_U != '0);
    assign push          = valid_in_H & ready_in_H;
    assign enq           = push & ~reject;
    assign pop           = validTri_R10H & halt_RnnnnL;

    // Payload storage; no reset needed since empty slots are never shown
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int v = 0; v < VERTS; v++)
                for (int a = 0; a < AXIS; a++)
                    tri_mem[tail][v][a] <= tri_in_S[v][a];
            for (int c = 0; c < COLORS; c++)
                color_mem[tail][c] <= color_in_U[c];
        end
    end

    // Pointers, occupancy and saturating cull counter
    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            occupancy_U  <= '0;
            cull_count_U <= '0;
        end else begin
            if (enq)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            unique case ({enq, pop})
                2'b10:   occupancy_U <= occupancy_U + 1'b1;
                2'b01:   occupancy_U <= occupancy_U - 1'b1;
                default: occupancy_U <= occupancy_U;
            endcase
            if (push && reject && cull_count_U != '1)
                cull_count_U <= cull_count_U + 1'b1;
        end
    end

    // Head entry drives the rasterizer straight from storage
    always_comb begin
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_R10S[v][a] = tri_mem[head][v][a];
        for (int c = 0; c < COLORS; c++)
            color_R10U[c] = color_mem[head][c];
    end

endmodule
